serial_subtractor: RTL
======================

# serial_subtractor

Bit-serial two's-complement subtractor computing `a - b - bin` one bit per clock, LSB first, with a single registered borrow flip-flop. It is the subtract-direction partner of the team's full-adder datapath cell. It is intended for area-constrained arithmetic paths where an N-bit parallel subtractor is not justified. Operands enter and results leave through valid/ready handshakes.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operands `a`, `b`, `bin` are valid.
- `in_ready`, output, 1: block can accept operands. High only in IDLE.
- `a`, input, WIDTH: minuend, unsigned or two's-complement.
- `b`, input, WIDTH: subtrahend.
- `bin`, input, 1: borrow-in.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `diff`, output, WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout`, output, 1: borrow-out; 1 when unsigned `a < b + bin`.
- `ovf`, output, 1: signed overflow. Present only with `SERIAL_SUB_OVF_EN`.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`: latch `a` and `b` into shift registers, load the borrow flop with `bin`, clear the bit counter, and go to RUN.
- RUN, once per cycle:
  - Compute the LSB-cell difference `d = a0 ^ b0 ^ br`.
  - Compute the next borrow `(~a0 & b0) | (~a0 & br) | (b0 & br)`.
  - Shift `d` into the MSB of the diff register. Shift the operand registers right by 1.
  - Increment the counter.
  - After the bit at index WIDTH-1 is processed, go to DONE.
- DONE:
  - `out_valid` = 1. `diff`, `bout` and `ovf` are stable and held.
  - On `out_valid && out_ready`: go to IDLE.
- `in_valid` is ignored outside IDLE; the operand registers are not disturbed.
- Bit counter width is `$clog2(WIDTH)`. Compare against `WIDTH-1`; the counter never wraps during a valid operation.
- `bout` equals the borrow flop value after the final bit.
- Input operands need to be stable only in the accept cycle.

## Timing
- Reset values, asynchronous:
  - State = IDLE, `in_ready` = 1, `out_valid` = 0.
  - `diff` = 0, `bout` = 0, `ovf` = 0.
  - Operand registers, borrow flop and counter = 0.
- Accept edge T: RUN occupies edges T+1 .. T+WIDTH.
- `out_valid` rises after edge T+WIDTH, giving a latency of WIDTH+1 cycles from accept to result.
- The result persists indefinitely while `out_ready` = 0.
- After the result-transfer edge, `in_ready` = 1 in the next cycle. There is no same-cycle accept in DONE.
- Minimum throughput: one operation per WIDTH+2 cycles.
- `rst` asserted mid-RUN or mid-DONE aborts immediately and discards the operation. Outputs take their reset values; no partial result is ever flagged valid.
- `in_ready` and `out_valid` are decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SERIAL_SUB_OVF_EN`.
- When defined:
  - Port `ovf` exists.
  - `ovf` is registered at the MSB step as borrow-into-MSB XOR borrow-out-of-MSB, i.e. the signed result of `a - b - bin` is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - `ovf` is valid with `out_valid` and resets to 0.
- When undefined:
  - Port `ovf` and its flop are absent.
  - All other behaviour is identical.

## Test plan
- **Basic subtract:** WIDTH=8, accept `a=0x35 b=0x12 bin=0`, `out_ready=1` → `out_valid` exactly 9 cycles after accept, `diff=0x23`, `bout=0`; `in_ready` high the cycle after transfer.
- **Underflow:** `a=0x00 b=0x01 bin=0` → `diff=0xFF`, `bout=1`.
- **Borrow-in, signed overflow (with `SERIAL_SUB_OVF_EN`):**
  - `a=0xAA b=0xAA bin=1` → `diff=0xFF`, `bout=1`, `ovf=0`.
  - `a=0x80 b=0x01 bin=0` → `diff=0x7F`, `bout=0`, `ovf=1`.
- **Back-pressure:** hold `out_ready=0` for 5 cycles after `out_valid` → `diff`, `bout` and `out_valid` stable, `in_ready=0`. Drive `in_valid` with new operands during this window → ignored, and the first result is unchanged.
- **Reset mid-operation:** assert `rst` 3 cycles into RUN → `out_valid=0` and `in_ready=1` immediately. Then accept `a=0x10 b=0x03` → `diff=0x0D`, `bout=0` after 9 cycles.
- **Back-to-back operations:** `out_ready` tied high, `in_valid` held high with a new operand each accept → one result per 10 cycles, all results correct.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one bit per clock.
// Uses one registered borrow flop and valid/ready handshakes on both sides.
//
// Parameters:
//   WIDTH      operand/result width (>= 2)
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands a/b/bin valid
//   in_ready   accepting operands (IDLE only)
//   a, b, bin  minuend, subtrahend, borrow-in
//   out_valid  diff/bout(/ovf) valid (DONE only)
//   out_ready  consumer takes the result
//   diff       (a - b - bin) mod 2^WIDTH
//   bout       borrow-out (unsigned a < b + bin)
//   ovf        signed overflow; only with SERIAL_SUB_OVF_EN defined
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic a0;
    logic b0;
    logic d_bit;
    logic br_nx;
    logic last;
    logic accept;

    // One full-subtractor cell working on the current LSBs.
    always_comb begin
        a0     = a_sr[0];
        b0     = b_sr[0];
        d_bit  = a0 ^ b0 ^ br;
        br_nx  = (~a0 & b0) | (~a0 & br) | (b0 & br);
        last   = (cnt == LAST);
        accept = (state == IDLE) && in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Handshake outputs come straight from the state register.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr <= '0;
            b_sr <= '0;
            d_sr <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            cnt  <= '0;
        end else if (state == RUN) begin
            // Result bits enter at the MSB so after WIDTH steps bit 0
            // has reached the LSB position.
            d_sr <= {d_bit, d_sr[WIDTH-1:1]};
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            br   <= br_nx;
            // Hold at the last index instead of wrapping.
            if (!last) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign diff = d_sr;
    assign bout = br;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_r;

    // Borrow into the MSB differs from borrow out of it exactly when
    // the signed result leaves the representable range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if ((state == RUN) && last) begin
            ovf_r <= br ^ br_nx;
        end
    end

    assign ovf = ovf_r;
`endif

endmodule
